// File: rtl/ncc_result_tx.sv
// Result packetiser: buffers {score, x, y} results in a small FIFO and emits each one as an
// 11-byte framed packet (header, seq, 8 payload bytes, XOR checksum) over a byte-wide valid/ready port.
//
// state   | meaning
// IDLE    | nothing to send, waiting for a queued result
// HEADER  | presenting the header byte
// SEQ     | presenting the sequence number
// PAYLOAD | presenting the 8 payload bytes from the shift register
// CKSUM   | presenting the XOR of seq and payload bytes
module ncc_result_tx #(
    parameter int          depth  = 4,
    parameter logic [7:0]  header = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        resValid,
    output logic        resReady,
    input  logic [31:0] resScore,
    input  logic [9:0]  resX,
    input  logic [9:0]  resY,
    output logic [7:0]  pciOut,
    output logic        pciOutValid,
    input  logic        pciOutReady,
    output logic        busy,
    output logic [7:0]  seqNum
);

    localparam int aw = (depth > 1) ? $clog2(depth) : 1;

    localparam logic [2:0] st_idle    = 3'd0;
    localparam logic [2:0] st_header  = 3'd1;
    localparam logic [2:0] st_seq     = 3'd2;
    localparam logic [2:0] st_payload = 3'd3;
    localparam logic [2:0] st_cksum   = 3'd4;

    logic [51:0]   mem [depth];
    logic [aw-1:0] wr_ptr;
    logic [aw-1:0] rd_ptr;
    logic [aw:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          accept;
    logic [51:0]   rd_data;
    logic [63:0]   load_word;

    logic [2:0]    state;
    logic [63:0]   shreg;
    logic [7:0]    xor_r;
    logic [2:0]    byte_cnt;

    assign full     = (count == (aw + 1)'(depth));
    assign empty    = (count == '0);
    assign resReady = !full;
    assign push     = resValid && !full;
    assign accept   = pciOutValid && pciOutReady;
    // Pop happens on the edge that starts a packet, so it uses last cycle's occupancy only.
    assign pop      = !empty && ((state == st_idle) || ((state == st_cksum) && accept));
    assign rd_data  = mem[rd_ptr];
    assign load_word = {rd_data[51:20], 6'b0, rd_data[19:10], 6'b0, rd_data[9:0]};
    assign busy     = (state != st_idle) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {resScore, resX, resY};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= st_idle;
            shreg    <= '0;
            xor_r    <= '0;
            byte_cnt <= '0;
            seqNum   <= '0;
        end else begin
            case (state)
                st_idle: begin
                    if (!empty) begin
                        state <= st_header;
                        shreg <= load_word;
                        xor_r <= '0;
                    end
                end
                st_header: begin
                    if (accept) begin
                        state <= st_seq;
                    end
                end
                st_seq: begin
                    if (accept) begin
                        state    <= st_payload;
                        xor_r    <= seqNum;
                        byte_cnt <= '0;
                    end
                end
                st_payload: begin
                    if (accept) begin
                        shreg    <= {shreg[55:0], 8'h00};
                        xor_r    <= xor_r ^ shreg[63:56];
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == 3'd7) begin
                            state <= st_cksum;
                        end
                    end
                end
                st_cksum: begin
                    if (accept) begin
                        seqNum <= seqNum + 1'b1;
                        if (!empty) begin
                            state <= st_header;
                            shreg <= load_word;
                            xor_r <= '0;
                        end else begin
                            state <= st_idle;
                        end
                    end
                end
                default: state <= st_idle;
            endcase
        end
    end

    assign pciOutValid = (state != st_idle);

    always_comb begin
        pciOut = 8'h00;
        case (state)
            st_header:  pciOut = header;
            st_seq:     pciOut = seqNum;
            st_payload: pciOut = shreg[63:56];
            st_cksum:   pciOut = xor_r;
            default:    pciOut = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_ncc_result_tx.sv
// Bench for ncc_result_tx: a queue-of-bytes packet model predicts the full output stream from
// accepted results; directed scenarios add literal expectations on timing, capacity and reset.
module tb_ncc_result_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        resValid;
    logic        resReady;
    logic [31:0] resScore;
    logic [9:0]  resX;
    logic [9:0]  resY;
    logic [7:0]  pciOut;
    logic        pciOutValid;
    logic        pciOutReady;
    logic        busy;
    logic [7:0]  seqNum;

    ncc_result_tx #(.depth(4), .header(8'hA5)) dut (
        .clk(clk), .rst(rst),
        .resValid(resValid), .resReady(resReady),
        .resScore(resScore), .resX(resX), .resY(resY),
        .pciOut(pciOut), .pciOutValid(pciOutValid), .pciOutReady(pciOutReady),
        .busy(busy), .seqNum(seqNum)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int acc    = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cap[$];
    int         cap_cyc[$];
    logic [7:0] mseq;
    logic       prev_stall;
    logic [7:0] prev_byte;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Expected packet for one accepted result, straight from the framing rules.
    task automatic model_packet(input logic [31:0] s, input logic [9:0] x, input logic [9:0] y,
                                input logic [7:0] sq);
        logic [7:0] b [0:10];
        logic [7:0] c;
        b[0] = 8'hA5;
        b[1] = sq;
        b[2] = s[31:24];
        b[3] = s[23:16];
        b[4] = s[15:8];
        b[5] = s[7:0];
        b[6] = {6'b0, x[9:8]};
        b[7] = x[7:0];
        b[8] = {6'b0, y[9:8]};
        b[9] = y[7:0];
        c = 8'h00;
        for (int i = 1; i <= 9; i++) c = c ^ b[i];
        b[10] = c;
        for (int i = 0; i <= 10; i++) exp_q.push_back(b[i]);
    endtask

    task automatic monitor();
        if (rst) begin
            exp_q.delete();
            mseq = 8'h00;
            prev_stall = 1'b0;
            return;
        end
        if (prev_stall) begin
            check("stall_valid", pciOutValid, 1);
            check("stall_hold", pciOut, prev_byte);
        end
        if (pciOutValid && pciOutReady) begin
            if (exp_q.size() == 0) fail("unexpected_byte");
            else check("stream", pciOut, exp_q.pop_front());
            cap.push_back(pciOut);
            cap_cyc.push_back(cyc);
        end
        prev_stall = pciOutValid && !pciOutReady;
        prev_byte  = pciOut;
        if (resValid && resReady) begin
            model_packet(resScore, resX, resY, mseq);
            mseq++;
            acc++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rand_result();
        resScore = $urandom;
        resX     = 10'($urandom_range(0, 639));
        resY     = 10'($urandom_range(0, 1023));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        resValid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        acc = 0;
        cap.delete();
        cap_cyc.delete();
    endtask

    task automatic wait_bytes(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (cap.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (cap.size() < n) fail({name, "_timeout"});
    endtask

    initial begin
        logic [7:0] lit [0:10];
        int c0;
        int k;
        lit = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h01, 8'hFF, 8'h00, 8'h03, 8'hF5};
        rst = 1'b1;
        resValid = 1'b0;
        pciOutReady = 1'b1;
        resScore = '0;
        resX = '0;
        resY = '0;
        mseq = 8'h00;
        prev_stall = 1'b0;
        prev_byte = 8'h00;
        tick();
        tick();
        check("rst_valid", pciOutValid, 0);
        check("rst_byte", pciOut, 8'h00);
        check("rst_seq", seqNum, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", resReady, 1);
        rst = 1'b0;
        tick();

        // Single known result
        cap.delete(); cap_cyc.delete();
        resValid = 1'b1; resScore = 32'h12345678; resX = 10'h1FF; resY = 10'h003;
        c0 = cyc;
        tick();
        resValid = 1'b0;
        wait_bytes(11, 40, "t1");
        for (int i = 0; i < 11; i++) check("t1_byte", cap[i], lit[i]);
        check("t1_latency", cap_cyc[0] - c0, 2);
        check("t1_contig", cap_cyc[10] - cap_cyc[0], 10);
        check("t1_seq_after", seqNum, 1);
        check("t1_busy_after", busy, 0);

        // Capacity with stalled sink, then drain
        do_reset();
        pciOutReady = 1'b0;
        for (int i = 0; i < 20; i++) begin
            resValid = 1'b1;
            rand_result();
            tick();
        end
        resValid = 1'b0;
        check("cap_accepted", acc, 5);
        check("cap_ready_low", resReady, 0);
        check("cap_busy", busy, 1);
        pciOutReady = 1'b1;
        cap.delete(); cap_cyc.delete();
        wait_bytes(55, 100, "drain");
        check("drain_contig", cap_cyc[54] - cap_cyc[0], 54);
        for (int p = 0; p < 5; p++) check("drain_seq", cap[p * 11 + 1], p);

        // Random backpressure over 20 packets
        do_reset();
        k = 0;
        while (acc < 20 && k < 3000) begin
            resValid = (($urandom % 2) == 0);
            rand_result();
            pciOutReady = (($urandom % 2) == 0);
            tick();
            k++;
        end
        resValid = 1'b0;
        k = 0;
        while (cap.size() < 220 && k < 3000) begin
            pciOutReady = (($urandom % 2) == 0);
            tick();
            k++;
        end
        check("rand_bytes", cap.size(), 220);
        check("rand_left", exp_q.size(), 0);
        pciOutReady = 1'b1;

        // Sequence wrap over 257 back-to-back packets
        do_reset();
        k = 0;
        while (cap.size() < 257 * 11 && k < 4000) begin
            resValid = (acc < 257);
            rand_result();
            tick();
            k++;
        end
        resValid = 1'b0;
        check("wrap_bytes", cap.size(), 257 * 11);
        check("wrap_seq_ff", cap[255 * 11 + 1], 8'hFF);
        check("wrap_seq_00", cap[256 * 11 + 1], 8'h00);
        check("wrap_contig", cap_cyc[257 * 11 - 1] - cap_cyc[0], 257 * 11 - 1);
        check("wrap_seqnum", seqNum, 8'h01);

        // Push landing on the checksum-accept edge: FIFO looked empty, one IDLE cycle
        do_reset();
        resValid = 1'b1; rand_result();
        tick();
        k = 0;
        while (cap.size() < 22 && k < 60) begin
            resValid = (cap.size() == 10 && acc == 1);
            rand_result();
            tick();
            k++;
        end
        resValid = 1'b0;
        check("cks_same_push", acc, 2);
        check("cks_same_gap", cap_cyc[11] - cap_cyc[10], 2);

        // Push one edge earlier: next header directly after the checksum
        do_reset();
        resValid = 1'b1; rand_result();
        tick();
        k = 0;
        while (cap.size() < 22 && k < 60) begin
            resValid = (cap.size() == 9 && acc == 1);
            rand_result();
            tick();
            k++;
        end
        resValid = 1'b0;
        check("cks_early_push", acc, 2);
        check("cks_early_gap", cap_cyc[11] - cap_cyc[10], 1);

        // Reset in the middle of a payload with two results queued
        do_reset();
        pciOutReady = 1'b0;
        k = 0;
        while (acc < 3 && k < 20) begin
            resValid = 1'b1;
            rand_result();
            tick();
            k++;
        end
        resValid = 1'b0;
        check("mid_queued", acc, 3);
        tick();
        pciOutReady = 1'b1;
        wait_bytes(4, 20, "mid");
        rst = 1'b1;
        #1;
        check("mid_rst_valid", pciOutValid, 0);
        check("mid_rst_seq", seqNum, 0);
        check("mid_rst_ready", resReady, 1);
        tick();
        rst = 1'b0;
        tick();
        check("mid_after_valid", pciOutValid, 0);
        check("mid_after_busy", busy, 0);
        cap.delete(); cap_cyc.delete();
        resValid = 1'b1; rand_result();
        tick();
        resValid = 1'b0;
        wait_bytes(11, 40, "mid_new");
        check("mid_new_seq", cap[1], 8'h00);
        tick();
        tick();
        check("end_left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
